// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter
// Lets two Wishbone classic masters share one simple-dual-port 32-bit block RAM.
// Masters are granted in round-robin order and served one access at a time.
// Each access takes three cycles: IDLE (grant), ACCESS (RAM address/write) and
// RESP (ack plus read data from the RAM's registered read port).

module wb_ram_arbiter #(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [31:0]   m0_adr,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [31:0]   m1_adr,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack,

    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [31:0]   ram_din,
    output logic [AW-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   prio_q, prio_d;

    logic          req0;
    logic          req1;
    logic          grantReq;
    logic          grantWe;
    logic [3:0]    grantSel;
    logic [AW-1:0] grantWord;
    logic [31:0]   grantDat;

    // Byte-offset bits and bits above the RAM depth are ignored, so addresses alias.
    logic unusedAdrBits;
    assign unusedAdrBits = ^{m0_adr[31:AW+2], m0_adr[1:0], m1_adr[31:AW+2], m1_adr[1:0]};

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    assign grantReq  = gnt_q ? req1 : req0;
    assign grantWe   = gnt_q ? m1_we : m0_we;
    assign grantSel  = gnt_q ? m1_sel : m0_sel;
    assign grantWord = gnt_q ? m1_adr[AW+1:2] : m0_adr[AW+1:2];
    assign grantDat  = gnt_q ? m1_dat_i : m0_dat_i;

    // State, grant and priority registers; reset returns to IDLE favouring master 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state and output decode; all outputs derive from the state so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        ram_we    = 4'b0;
        ram_waddr = '0;
        ram_raddr = '0;
        ram_din   = 32'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_dat_o  = 32'b0;
        m1_dat_o  = 32'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = (req0 && req1) ? prio_q : req1;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                ram_waddr = grantWord;
                ram_raddr = grantWord;
                ram_din   = grantDat;
                if (grantWe && grantReq) begin
                    ram_we = grantSel;
                end
                state_d = grantReq ? RESP : IDLE;
            end

            RESP: begin
                if (grantReq) begin
                    if (gnt_q) begin
                        m1_ack   = 1'b1;
                        m1_dat_o = ram_dout;
                    end else begin
                        m0_ack   = 1'b1;
                        m0_dat_o = ram_dout;
                    end
                end
                prio_d  = ~gnt_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
